mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 4, cycles from first sampled mio_en to rdy; legal 2..15.
REQ-002 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port bus  inout  16  shared CPU datapath bus.
REQ-005 SHALL have port ld_mar  in  1  load MAR from bus.
REQ-006 SHALL have port ld_mdr  in  1  load MDR.
REQ-007 SHALL have port gate_mdr  in  1  drive MDR onto bus.
REQ-008 SHALL have port mio_en  in  1  memory/IO access request.
REQ-009 SHALL have port rw  in  1  access direction: 1 = write, 0 = read.
REQ-010 SHALL have port rdy  out  1  access-complete qualifier to microsequencer.
REQ-011 SHALL have ports sram_en, sram_we (out, 1), sram_addr, sram_wdata (out, 16) and sram_rdata (in, 16); the SRAM is synchronous, rdata valid the cycle after a sampled read.
REQ-012 SHALL have ports kbd_valid (in, 1), kbd_data (in, 8), disp_ack (in, 1), disp_valid (out, 1) and disp_data (out, 8).

Function
REQ-013 ld_mar: MAR <= bus at the edge.
REQ-014 ld_mdr with mio_en=0: MDR <= bus; ld_mdr with mio_en=1 and rdy=0: MDR holds.
REQ-015 gate_mdr=1: bus = MDR; otherwise all 16 bus bits are high-Z.
REQ-016 Address map: x0000-xFDFF go to SRAM; KBSR=xFE00, KBDR=xFE02, DSR=xFE04, DDR=xFE06; other xFE00-xFFFF addresses are unmapped.
REQ-017 FSM states are IDLE, BUSY and READY; IDLE->BUSY when mio_en is sampled at edge k.
REQ-018 BUSY counts with a 4-bit counter; BUSY->READY at edge k+LATENCY-1 for SRAM accesses, and at edge k+1 for I/O and unmapped accesses.
REQ-019 rdy SHALL be registered and high only in READY, for exactly one cycle.
REQ-020 READY->IDLE unconditionally at the next edge (the commit edge); if mio_en is still high in IDLE, a new access starts.
REQ-021 SRAM read: sram_en=1, sram_we=0, sram_addr=MAR during the IDLE cycle with mio_en&!rw; sram_rdata is captured into an internal read buffer one edge later.
REQ-022 Read commit: at the commit edge, if ld_mdr then MDR <= read buffer (SRAM), the I/O register value, or x0000 (unmapped).
REQ-023 Write commit: during READY with mio_en&rw and an SRAM address, sram_en=sram_we=1, sram_addr=MAR and sram_wdata=MDR, for exactly one cycle.
REQ-024 mio_en dropped mid-access: the FSM completes to IDLE; no SRAM write and no I/O side effect occur.
REQ-025 KBSR = {ready,15'b0} and KBDR = {8'b0,char}; kbd_valid sets ready and loads char.
REQ-026 A committed KBDR read clears ready; if kbd_valid coincides with that clear, the set wins and char is updated.
REQ-027 DSR = {dready,15'b0}; a committed DDR write loads disp_data=MDR[7:0], clears dready and pulses disp_valid high for one cycle.
REQ-028 disp_ack sets dready; if disp_ack coincides with a DDR write, the clear wins.
REQ-029 KBSR, DSR, unmapped addresses and KBDR are read-only; writes to them are ignored.

Reset
REQ-030 rst_n low SHALL asynchronously force state=IDLE, counter=0, MAR=0, MDR=0, rdy=0, sram_en=sram_we=0, ready=0, char=0, dready=1, disp_valid=0 and disp_data=0.
REQ-031 Reset mid-access SHALL abort the access with no SRAM write and no MDR update; after release, operation resumes from IDLE.

Structure
REQ-032 Package lc3_mem_pkg SHALL hold the FSM state enum, the KBSR/KBDR/DSR/DDR address constants and the IO_BASE=xFE00 constant.
REQ-033 Sub-module mem_io SHALL hold the keyboard/display registers, the address decode and the read mux; mem_ctrl holds MAR, MDR, the FSM and the SRAM port.

Verification
REQ-034 LATENCY=4: MAR=x3000, SRAM[x3000]=x1234, mio_en+ld_mdr at edge k -> rdy high only in cycle k+3..k+4, MDR=x1234 after edge k+4.
REQ-035 MAR=x4000, MDR=xBEEF, mio_en+rw at edge k -> exactly one sram_we pulse in the READY cycle, addr x4000, data xBEEF; a subsequent read returns xBEEF.
REQ-036 kbd_valid with kbd_data=x41, then KBSR read -> MDR=x8000; KBDR read -> MDR=x0041, KBSR then reads x0000; kbd_valid on the KBDR commit edge -> KBSR stays x8000.
REQ-037 DDR write MDR=x0058 -> disp_valid pulses once, disp_data=x58, DSR reads x0000; disp_ack -> DSR reads x8000.
REQ-038 rst_n low during BUSY of a write to x5000 -> no sram_we, rdy stays 0, MAR=MDR=0, DSR=x8000 after release.
REQ-039 Unmapped read at xFE10 -> rdy at edge k+1, MDR=x0000, sram_en never asserted; gate_mdr=0 -> bus high-Z.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// Shared types and address constants for the LC-3 memory controller slice.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    READY = 2'd2
  } state_t;

  localparam logic [15:0] IO_BASE   = 16'hFE00;
  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

  function automatic logic is_sram_addr(input logic [15:0] addr);
    return addr < IO_BASE;
  endfunction

endpackage

// File: rtl/mem_io.sv
// Keyboard/display device registers, address decode and I/O read mux.
module mem_io
  import lc3_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic        commit,
  input  logic        rw,
  input  logic [7:0]  wdata,
  input  logic        kbd_valid,
  input  logic [7:0]  kbd_data,
  input  logic        disp_ack,
  output logic        is_sram,
  output logic [15:0] rdata,
  output logic        disp_valid,
  output logic [7:0]  disp_data
);

  logic       kb_ready;
  logic [7:0] kb_char;
  logic       dready;
  logic       kbdr_read;
  logic       ddr_write;

  assign is_sram   = is_sram_addr(addr);
  assign kbdr_read = commit && !rw && (addr == KBDR_ADDR);
  assign ddr_write = commit && rw && (addr == DDR_ADDR);

  // DDR is write-only, so it reads back as zero like unmapped space.
  always_comb begin
    rdata = 16'h0000;
    case (addr)
      KBSR_ADDR: rdata = {kb_ready, 15'b0};
      KBDR_ADDR: rdata = {8'b0, kb_char};
      DSR_ADDR:  rdata = {dready, 15'b0};
      default:   rdata = 16'h0000;
    endcase
  end

  // A new keystroke beats the clear from a simultaneous KBDR read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kb_ready <= 1'b0;
      kb_char  <= 8'h00;
    end else if (kbd_valid) begin
      kb_ready <= 1'b1;
      kb_char  <= kbd_data;
    end else if (kbdr_read) begin
      kb_ready <= 1'b0;
    end
  end

  // A DDR write beats a simultaneous acknowledge from the display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dready     <= 1'b1;
      disp_valid <= 1'b0;
      disp_data  <= 8'h00;
    end else begin
      disp_valid <= ddr_write;
      if (ddr_write) begin
        dready    <= 1'b0;
        disp_data <= wdata;
      end else if (disp_ack) begin
        dready <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// LC-3 style memory controller: MAR/MDR, access FSM with rdy handshake,
// synchronous SRAM port and memory-mapped keyboard/display.
module mem_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  inout  wire  [15:0] bus,
  input  logic        ld_mar,
  input  logic        ld_mdr,
  input  logic        gate_mdr,
  input  logic        mio_en,
  input  logic        rw,
  output logic        rdy,
  output logic        sram_en,
  output logic        sram_we,
  output logic [15:0] sram_addr,
  output logic [15:0] sram_wdata,
  input  logic [15:0] sram_rdata,
  input  logic        kbd_valid,
  input  logic [7:0]  kbd_data,
  input  logic        disp_ack,
  output logic        disp_valid,
  output logic [7:0]  disp_data
);

  localparam logic [3:0] LAST_COUNT = 4'(LATENCY - 1);

  state_t      state;
  logic [3:0]  count;
  logic [15:0] mar;
  logic [15:0] mdr;
  logic [15:0] read_buf;
  logic        read_pending;
  logic        is_sram;
  logic [15:0] io_rdata;
  logic        commit;
  logic        sram_rd;
  logic        sram_wr;

  assign bus        = gate_mdr ? mdr : 16'bz;
  assign commit     = (state == READY) && mio_en;
  assign sram_addr  = mar;
  assign sram_wdata = mdr;

  // The read is issued in the request cycle so data lands well before commit;
  // rst_n gating keeps the SRAM quiet while reset is held with mio_en high.
  assign sram_rd = rst_n && (state == IDLE) && mio_en && !rw && is_sram;
  assign sram_wr = rst_n && commit && rw && is_sram;
  assign sram_en = sram_rd || sram_wr;
  assign sram_we = sram_wr;

  mem_io u_io (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (mar),
    .commit     (commit),
    .rw         (rw),
    .wdata      (mdr[7:0]),
    .kbd_valid  (kbd_valid),
    .kbd_data   (kbd_data),
    .disp_ack   (disp_ack),
    .is_sram    (is_sram),
    .rdata      (io_rdata),
    .disp_valid (disp_valid),
    .disp_data  (disp_data)
  );

  // count starts at 1 on entry so READY is reached LATENCY-1 edges after the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= 4'd0;
      rdy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rdy <= 1'b0;
          if (mio_en) begin
            state <= BUSY;
            count <= 4'd1;
          end
        end
        BUSY: begin
          if (!is_sram || count == LAST_COUNT) begin
            state <= READY;
            rdy   <= 1'b1;
            count <= 4'd0;
          end else begin
            count <= count + 4'd1;
          end
        end
        READY: begin
          state <= IDLE;
          rdy   <= 1'b0;
        end
        default: begin
          state <= IDLE;
          rdy   <= 1'b0;
          count <= 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_pending <= 1'b0;
      read_buf     <= 16'h0000;
    end else begin
      read_pending <= sram_rd;
      if (read_pending) read_buf <= sram_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mar <= 16'h0000;
      mdr <= 16'h0000;
    end else begin
      if (ld_mar) mar <= bus;
      if (ld_mdr && !mio_en)
        mdr <= bus;
      else if (ld_mdr && commit && !rw)
        mdr <= is_sram ? read_buf : io_rdata;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus randomized SRAM traffic
// checked against a behavioural model of the memory map.
module tb_mem_ctrl;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  wire  [15:0] bus;
  logic [15:0] tb_bus;
  logic        tb_drive;
  logic        ld_mar, ld_mdr, gate_mdr, mio_en, rw;
  logic        rdy, sram_en, sram_we;
  logic [15:0] sram_addr, sram_wdata, sram_rdata;
  logic        kbd_valid, disp_ack, disp_valid;
  logic [7:0]  kbd_data, disp_data;

  int n_checks = 0;
  int n_fail   = 0;
  int we_pulses = 0;
  int en_count  = 0;
  int dv_pulses = 0;

  logic [15:0] sram_mem [0:65535];
  logic [15:0] ref_mem  [0:65535];

  logic [15:0] m_mar, m_mdr;
  logic        m_kready, m_dready;
  logic [7:0]  m_char, m_disp;

  assign bus = tb_drive ? tb_bus : 16'bz;

  always #5 clk = ~clk;

  mem_ctrl #(.LATENCY(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .ld_mar     (ld_mar),
    .ld_mdr     (ld_mdr),
    .gate_mdr   (gate_mdr),
    .mio_en     (mio_en),
    .rw         (rw),
    .rdy        (rdy),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .kbd_valid  (kbd_valid),
    .kbd_data   (kbd_data),
    .disp_ack   (disp_ack),
    .disp_valid (disp_valid),
    .disp_data  (disp_data)
  );

  // Synchronous SRAM and event counters
  always @(posedge clk) begin
    if (sram_en) begin
      en_count = en_count + 1;
      if (sram_we) begin
        sram_mem[sram_addr] <= sram_wdata;
        we_pulses = we_pulses + 1;
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
    if (disp_valid) dv_pulses = dv_pulses + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [15:0] io_val(input logic [15:0] a);
    case (a)
      16'hFE00: return {m_kready, 15'b0};
      16'hFE02: return {8'b0, m_char};
      16'hFE04: return {m_dready, 15'b0};
      default:  return 16'h0000;
    endcase
  endfunction

  task automatic model_reset();
    m_mar = 16'h0; m_mdr = 16'h0; m_kready = 1'b0; m_char = 8'h0;
    m_dready = 1'b1; m_disp = 8'h0;
  endtask

  task automatic load_mar(input logic [15:0] v);
    tb_bus = v; tb_drive = 1'b1; ld_mar = 1'b1;
    applyStimulus(1);
    ld_mar = 1'b0; tb_drive = 1'b0;
    m_mar = v;
  endtask

  task automatic load_mdr(input logic [15:0] v);
    tb_bus = v; tb_drive = 1'b1; ld_mdr = 1'b1; mio_en = 1'b0;
    applyStimulus(1);
    ld_mdr = 1'b0; tb_drive = 1'b0;
    m_mdr = v;
  endtask

  task automatic check_mdr(input string tag);
    gate_mdr = 1'b1;
    #1;
    checkOutput(tag, bus, m_mdr);
    gate_mdr = 1'b0;
    #1;
  endtask

  task automatic pulse_kbd(input logic [7:0] d);
    kbd_valid = 1'b1; kbd_data = d;
    applyStimulus(1);
    kbd_valid = 1'b0;
    m_kready = 1'b1; m_char = d;
  endtask

  // side: 0 none, 1 kbd_valid on the commit edge, 2 disp_ack on the commit edge
  task automatic do_access(input bit wr, input int side, input logic [7:0] side_data,
                           input bit drop);
    logic [15:0] a;
    bit sram, ddr_commit;
    int n, lat, we0, en0, dv0, exp_we, exp_dv, exp_en;
    a = m_mar;
    sram = (a < 16'hFE00);
    we0 = we_pulses; en0 = en_count; dv0 = dv_pulses;
    rw = wr; ld_mdr = !wr && !drop; mio_en = 1'b1;
    #1;
    if (!wr) checkOutput("req_cycle_sram_en", {sram_en, sram_we}, {sram, 1'b0});
    lat = sram ? LAT - 1 : 1;
    n = -1;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1);
      if (drop && i == 0) mio_en = 1'b0;
      if (rdy) begin
        n = i;
        break;
      end
    end
    checkOutput("rdy_latency", n, lat);
    if (wr && !drop && sram) begin
      checkOutput("wr_en_we", {sram_en, sram_we}, 2'b11);
      checkOutput("wr_addr", sram_addr, a);
      checkOutput("wr_data", sram_wdata, m_mdr);
    end
    if (side == 1) begin kbd_valid = 1'b1; kbd_data = side_data; end
    if (side == 2) disp_ack = 1'b1;
    applyStimulus(1);
    kbd_valid = 1'b0; disp_ack = 1'b0;
    mio_en = 1'b0; ld_mdr = 1'b0; rw = 1'b0;
    checkOutput("rdy_one_cycle", rdy, 1'b0);
    applyStimulus(1);

    exp_we = 0; exp_dv = 0;
    ddr_commit = !drop && wr && (a == 16'hFE06);
    if (!drop) begin
      if (wr) begin
        if (sram) begin ref_mem[a] = m_mdr; exp_we = 1; end
        else if (ddr_commit) begin m_disp = m_mdr[7:0]; exp_dv = 1; end
      end else begin
        m_mdr = sram ? ref_mem[a] : io_val(a);
        if (a == 16'hFE02) m_kready = 1'b0;
      end
    end
    if (side == 1) begin m_kready = 1'b1; m_char = side_data; end
    if (ddr_commit) m_dready = 1'b0;
    else if (side == 2) m_dready = 1'b1;
    exp_en = (sram && !(wr && drop)) ? 1 : 0;

    checkOutput("we_pulses", we_pulses - we0, exp_we);
    checkOutput("sram_en_count", en_count - en0, exp_en);
    checkOutput("disp_valid_pulses", dv_pulses - dv0, exp_dv);
    checkOutput("disp_data", disp_data, m_disp);
    if (!wr && !drop) check_mdr("read_mdr");
  endtask

  initial begin
    logic [15:0] ra, rv;
    int we0;
    tb_bus = 16'h0; tb_drive = 1'b0;
    ld_mar = 1'b0; ld_mdr = 1'b0; gate_mdr = 1'b1; mio_en = 1'b1; rw = 1'b0;
    kbd_valid = 1'b0; kbd_data = 8'h0; disp_ack = 1'b0; sram_rdata = 16'h0;
    for (int i = 0; i < 65536; i++) begin
      rv = 16'($urandom);
      sram_mem[i] = rv;
      ref_mem[i]  = rv;
    end
    sram_mem[16'h3000] = 16'h1234;
    ref_mem[16'h3000]  = 16'h1234;
    model_reset();

    // Reset state, with mio_en held high to show the SRAM stays idle
    #12;
    checkOutput("reset_rdy", rdy, 1'b0);
    checkOutput("reset_sram_en_we", {sram_en, sram_we}, 2'b00);
    checkOutput("reset_mar", sram_addr, 16'h0000);
    checkOutput("reset_mdr", bus, 16'h0000);
    checkOutput("reset_disp", {disp_valid, disp_data}, 9'h000);
    gate_mdr = 1'b0; mio_en = 1'b0;
    rst_n = 1'b1;
    applyStimulus(1);

    $display("[TB] SRAM read latency");
    load_mar(16'h3000);
    do_access(1'b0, 0, 8'h0, 1'b0);

    $display("[TB] SRAM write then read back");
    load_mar(16'h4000);
    load_mdr(16'hBEEF);
    do_access(1'b1, 0, 8'h0, 1'b0);
    do_access(1'b0, 0, 8'h0, 1'b0);

    $display("[TB] Keyboard");
    pulse_kbd(8'h41);
    load_mar(16'hFE00); do_access(1'b0, 0, 8'h0, 1'b0);
    load_mar(16'hFE02); do_access(1'b0, 0, 8'h0, 1'b0);
    load_mar(16'hFE00); do_access(1'b0, 0, 8'h0, 1'b0);
    pulse_kbd(8'h41);
    load_mar(16'hFE02); do_access(1'b0, 1, 8'h5A, 1'b0);
    load_mar(16'hFE00); do_access(1'b0, 0, 8'h0, 1'b0);
    load_mar(16'hFE02); do_access(1'b0, 0, 8'h0, 1'b0);

    $display("[TB] Display");
    load_mar(16'hFE06);
    load_mdr(16'h0058);
    do_access(1'b1, 0, 8'h0, 1'b0);
    load_mar(16'hFE04); do_access(1'b0, 0, 8'h0, 1'b0);
    disp_ack = 1'b1; applyStimulus(1); disp_ack = 1'b0; m_dready = 1'b1;
    load_mar(16'hFE04); do_access(1'b0, 0, 8'h0, 1'b0);
    load_mar(16'hFE06);
    load_mdr(16'h0063);
    do_access(1'b1, 2, 8'h0, 1'b0);
    load_mar(16'hFE04); do_access(1'b0, 0, 8'h0, 1'b0);

    $display("[TB] Read-only registers ignore writes");
    load_mar(16'hFE02);
    load_mdr(16'h1111);
    do_access(1'b1, 0, 8'h0, 1'b0);
    do_access(1'b0, 0, 8'h0, 1'b0);
    load_mar(16'hFE04);
    load_mdr(16'hFFFF);
    do_access(1'b1, 0, 8'h0, 1'b0);
    do_access(1'b0, 0, 8'h0, 1'b0);

    $display("[TB] mio_en dropped mid-access");
    load_mar(16'h2000);
    load_mdr(16'h7777);
    do_access(1'b1, 0, 8'h0, 1'b1);
    do_access(1'b0, 0, 8'h0, 1'b0);
    load_mar(16'hFE06);
    load_mdr(16'h00AA);
    do_access(1'b1, 0, 8'h0, 1'b1);

    $display("[TB] Unmapped read");
    load_mar(16'hFE10);
    do_access(1'b0, 0, 8'h0, 1'b0);
    tb_bus = 16'h5A5A; tb_drive = 1'b1; gate_mdr = 1'b0;
    #1;
    checkOutput("bus_released", bus, 16'h5A5A);
    tb_drive = 1'b0;

    $display("[TB] Reset during a write");
    load_mar(16'h5000);
    load_mdr(16'h9999);
    we0 = we_pulses;
    rw = 1'b1; mio_en = 1'b1;
    applyStimulus(1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_mid_rdy", rdy, 1'b0);
    #1;
    mio_en = 1'b0; rw = 1'b0;
    rst_n = 1'b1;
    model_reset();
    applyStimulus(1);
    checkOutput("reset_mid_rdy_after", rdy, 1'b0);
    applyStimulus(LAT + 2);
    checkOutput("reset_mid_no_we", we_pulses - we0, 0);
    checkOutput("reset_mid_mar", sram_addr, 16'h0000);
    check_mdr("reset_mid_mdr");
    load_mar(16'hFE04); do_access(1'b0, 0, 8'h0, 1'b0);
    load_mar(16'h5000); do_access(1'b0, 0, 8'h0, 1'b0);

    $display("[TB] Randomized SRAM traffic");
    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom_range(0, 7) * 16'h1000 + $urandom_range(0, 3));
      load_mar(ra);
      if ($urandom_range(0, 1) == 1) begin
        load_mdr(16'($urandom));
        do_access(1'b1, 0, 8'h0, 1'b0);
      end else begin
        do_access(1'b0, 0, 8'h0, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
